// File: rtl/restoring_divider.sv
// restoring_divider: iterative unsigned divider, one quotient bit per cycle.
// Each trial subtraction runs through an adder_substractor in subtract mode.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset (aborts any division)
//   start        request a division, sampled only while idle
//   dividend     unsigned dividend, sampled with start
//   divisor      unsigned divisor, sampled with start
//   busy         high whenever the divider is not idle
//   done         one-cycle pulse when results become valid
//   quotient     floor(dividend/divisor); all ones on divide-by-zero
//   remainder    dividend mod divisor; the dividend on divide-by-zero
//   div_by_zero  set with done when the divisor was zero
//
// adder_substractor: WIDTH-bit adder/subtractor.
//   add_or_substract=1 gives X+Y and add_or_substract=0 gives X-Y.
//   overflow flags signed (two's complement) overflow.

module adder_substractor #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             add_or_substract,
  output logic [WIDTH-1:0] S,
  output logic             overflow
);
  logic [WIDTH-1:0] y_eff;

  // Subtraction is X + ~Y + 1; the +1 enters as the carry-in.
  assign y_eff    = add_or_substract ? Y : ~Y;
  assign S        = X + y_eff + {{(WIDTH-1){1'b0}}, ~add_or_substract};
  assign overflow = (X[WIDTH-1] == y_eff[WIDTH-1]) && (S[WIDTH-1] != X[WIDTH-1]);
endmodule

module restoring_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] d_q, q_q, r_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             busy_q, done_q, dbz_q;

  // One restoring step: shift the next dividend bit into the partial
  // remainder, then keep the difference only if it did not go negative.
  logic [WIDTH-1:0] rs_lo, trial;
  logic             accept;
  logic [WIDTH-1:0] r_d, q_d;
  logic             sub_ovf_unused;

  assign rs_lo = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

  adder_substractor #(.WIDTH(WIDTH)) u_sub (
    .X                (rs_lo),
    .Y                (d_q),
    .add_or_substract (1'b0),
    .S                (trial),
    .overflow         (sub_ovf_unused)
  );

  // r_q[WIDTH-1] is the bit shifted out of rs_lo; if set, the shifted value
  // exceeds any WIDTH-bit divisor and the wrapped difference is exact.
  assign accept = r_q[WIDTH-1] | (rs_lo >= d_q);
  assign r_d    = accept ? trial : rs_lo;
  assign q_d    = {q_q[WIDTH-2:0], accept};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      d_q         <= '0;
      q_q         <= '0;
      r_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            d_q    <= divisor;
            q_q    <= dividend;
            r_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (divisor == '0) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              dbz_q       <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= dividend;
            end else begin
              state_q <= RUN;
              dbz_q   <= 1'b0;
            end
          end
        end
        RUN: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            quotient_q  <= q_d;
            remainder_q <= r_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks   = 0;
  int failures = 0;

  restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive start for one edge (inputs change on negedge), then wait for done
  // with a bounded loop. Latency counts negedges after the start edge.
  task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input int elat);
    int n, bc;
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dividend = '0; divisor = '0;
    n = 1; bc = 0;
    while (!done && n < 60) begin
      bc += int'(busy);
      @(negedge clk);
      n++;
    end
    bc += int'(busy);
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".lat"}, 64'(n), 64'(elat));
    chk({tag, ".busy_cycles"}, 64'(bc), 64'(elat));
    chk({tag, ".q"}, 64'(quotient), 64'(eq));
    chk({tag, ".r"}, 64'(remainder), 64'(er));
    chk({tag, ".dbz"}, 64'(div_by_zero), 64'(edz));
    @(negedge clk);
    chk({tag, ".done_pulse"}, 64'(done), 64'd0);
    chk({tag, ".idle"}, 64'(busy), 64'd0);
    chk({tag, ".q_held"}, 64'(quotient), 64'(eq));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int sawdone;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.q", 64'(quotient), 64'd0);
    chk("rst.r", 64'(remainder), 64'd0);
    chk("rst.dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    do_div("max_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    do_div("max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 33);
    do_div("d5_9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33);
    do_div("d0_3", 32'd0, 32'd3, 32'd0, 32'd0, 1'b0, 33);
    do_div("d1234_0", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1);
    do_div("d10_3", 32'd10, 32'd3, 32'd3, 32'd1, 1'b0, 33);

    // Abort: 1000/10 running, a stray start at cycle 5, reset at cycle 20.
    dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sawdone = 0;
    for (int c = 1; c < 20; c++) begin
      if (c == 5) begin
        dividend = 32'd7; divisor = 32'd7; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      sawdone += int'(done);
      @(negedge clk);
    end
    start = 1'b0;
    chk("abort.no_done_before_rst", 64'(sawdone), 64'd0);
    chk("abort.busy_before_rst", 64'(busy), 64'd1);
    chk("abort.q_before_rst", 64'(quotient), 64'd3);
    #2 rst = 1'b1;
    #1;
    chk("abort.rst_busy", 64'(busy), 64'd0);
    chk("abort.rst_q", 64'(quotient), 64'd0);
    chk("abort.rst_r", 64'(remainder), 64'd1 - 64'd1);
    chk("abort.rst_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sawdone = 0;
    repeat (40) begin
      @(negedge clk);
      sawdone += int'(done);
    end
    chk("abort.no_done_after", 64'(sawdone), 64'd0);
    do_div("restart", 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 33);

    // Random operands; the divisor is shifted to spread quotient sizes.
    for (int i = 0; i < 256; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == '0) rb = 32'd1;
      do_div("rand", ra, rb, ra / rb, ra % rb, 1'b0, 33);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Iterative unsigned integer divider for the ALU lab datapath.
- Sits downstream of adder_substractor: each step consumes one subtract result from an instance of that block, run in subtract mode (add_or_substract=0).
- Produces quotient and remainder over WIDTH cycles behind a start/busy/done handshake.
- Provides the divide operation that the ALU's single-cycle arithmetic cannot.

Parameters:
- WIDTH, 32, operand/result width in bits. Must equal the adder_substractor width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a division. Sampled only in IDLE.
- dividend  input  WIDTH  unsigned dividend. Sampled with start.
- divisor  input  WIDTH  unsigned divisor. Sampled with start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  WIDTH  result quotient. Held until the next accepted start.
- remainder  output  WIDTH  result remainder. Held until the next accepted start.
- div_by_zero  output  1  set with done when divisor was 0. Held until the next accepted start.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, counter=0.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal operand/partial-remainder registers cleared.
  - Reset mid-operation aborts the division; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches D=divisor and Q=dividend, sets R=0, clears div_by_zero.
  - If divisor==0: next state DONE. quotient={WIDTH{1'b1}}, remainder=dividend, div_by_zero=1.
  - Otherwise: next state RUN, counter=0.
- RUN, one iteration per edge:
  - Rs = {R, Q[WIDTH-1]} (WIDTH+1 bits). Q shifts left by 1.
  - Trial difference Rs[WIDTH-1:0] - D comes from the adder_substractor instance (X=Rs[WIDTH-1:0], Y=D, add_or_substract=0); its overflow output is unused.
  - Accept when Rs[WIDTH]==1 or Rs[WIDTH-1:0] >= D (unsigned).
  - Accept: R = trial difference (low WIDTH bits), Q[0]=1.
  - Reject: R = Rs[WIDTH-1:0], Q[0]=0.
  - counter increments. When counter reaches WIDTH-1 on an edge, that is the last iteration; next state DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - quotient=Q and remainder=R are registered on entry to DONE and valid in this cycle.
  - Next state IDLE unconditionally.
- Latency:
  - Normal case: start sampled at edge E0; done high in the cycle after edge E(WIDTH), i.e. WIDTH+1 cycles after start. For WIDTH=32 that is 33 cycles.
  - Divide-by-zero case: done high 1 cycle after start.
- Handshake:
  - start is ignored while busy=1, including in the DONE cycle. Back-to-back throughput is one division per WIDTH+2 cycles.
  - Inputs need only be valid on the start edge.
- Results:
  - quotient = floor(dividend/divisor), remainder = dividend mod divisor.
  - Invariant: remainder < divisor whenever divisor != 0.
  - Outputs are stable between done pulses.

Test Plan:
- 100 / 7 -> after 33 cycles: done=1, quotient=14, remainder=2, div_by_zero=0; busy high for 33 cycles.
- 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0. Also 0xFFFFFFFF / 0xFFFFFFFF -> quotient=1, remainder=0.
- 5 / 9 -> quotient=0, remainder=5. Also 0 / 3 -> quotient=0, remainder=0.
- 1234 / 0 -> done one cycle after start: quotient=0xFFFFFFFF, remainder=1234, div_by_zero=1. A following 10/3 -> quotient=3, remainder=1, div_by_zero=0.
- Start 1000/10, pulse start with 7/7 at cycle 5, then assert rst at cycle 20 -> second start ignored; outputs return to 0 immediately on rst; no done pulse. Restart 1000/10 -> quotient=100, remainder=0.
- 256 random $random operand pairs (divisor forced nonzero) -> quotient==dividend/divisor and remainder==dividend%divisor on every done. Bench counts mismatches and reports TEST SUCCESS or FAILURE.
